// File: rtl/lycan_pkg.sv
// Shared types and width helpers for the pin crossbar.
// Readback is enabled in pin_crossbar by defining PIN_CROSSBAR_READBACK_EN.
package lycan;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        APPLY
    } xbar_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned n_out(input int unsigned num_periph,
                                          input int unsigned outputs_per_periph);
        return num_periph * outputs_per_periph;
    endfunction

    function automatic int unsigned n_in(input int unsigned num_periph,
                                         input int unsigned inputs_per_periph);
        return num_periph * inputs_per_periph;
    endfunction

    function automatic int unsigned osel_w(input int unsigned num_out);
        return $clog2(num_out + 1);
    endfunction

    function automatic int unsigned isel_w(input int unsigned num_pins);
        return $clog2(num_pins + 1);
    endfunction

    function automatic int unsigned cfg_dw(input int unsigned num_out,
                                           input int unsigned num_pins);
        return max_u(osel_w(num_out), isel_w(num_pins));
    endfunction

    function automatic int unsigned cfg_aw(input int unsigned num_pins,
                                           input int unsigned num_in);
        return $clog2(max_u(num_pins, num_in)) + 1;
    endfunction

endpackage

// File: rtl/pin_crossbar_pin_sync.sv
// Single-bit multi-flop input synchroniser, cleared to 0 on reset.
module pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/pin_crossbar.sv
// Runtime-configurable pin routing fabric with shadow/active tables and break-before-make commit.
// Optional active-table readback port when PIN_CROSSBAR_READBACK_EN is defined.
module pin_crossbar
    import lycan::*;
#(
    parameter int unsigned NUM_PINS           = 16,
    parameter int unsigned NUM_PERIPHERALS    = 8,
    parameter int unsigned OUTPUTS_PER_PERIPH = 4,
    parameter int unsigned INPUTS_PER_PERIPH  = 4,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned HIZ_CYCLES         = 2,
    localparam int unsigned N_OUT  = n_out(NUM_PERIPHERALS, OUTPUTS_PER_PERIPH),
    localparam int unsigned N_IN   = n_in(NUM_PERIPHERALS, INPUTS_PER_PERIPH),
    localparam int unsigned OSEL_W = osel_w(N_OUT),
    localparam int unsigned ISEL_W = isel_w(NUM_PINS),
    localparam int unsigned CFG_DW = cfg_dw(N_OUT, NUM_PINS),
    localparam int unsigned CFG_AW = cfg_aw(NUM_PINS, N_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_AW-1:0]   cfg_addr,
    input  logic [CFG_DW-1:0]   cfg_data,
    input  logic                cfg_commit,
    output logic                commit_done,
    output logic                cfg_err,
    input  logic                cfg_err_clr,
    input  logic [N_OUT-1:0]    periph_out,
    input  logic [N_OUT-1:0]    periph_oe,
    output logic [N_IN-1:0]     periph_in,
    output logic [NUM_PINS-1:0] pin_o,
    output logic [NUM_PINS-1:0] pin_oe,
`ifdef PIN_CROSSBAR_READBACK_EN
    input  logic                cfg_rd_en,
    output logic [CFG_DW-1:0]   cfg_rdata,
`endif
    input  logic [NUM_PINS-1:0] pin_i
);

    localparam int unsigned CNT_W = $clog2(HIZ_CYCLES + 1);

    xbar_state_t      state;
    logic [CNT_W-1:0] hiz_cnt;

    logic [OSEL_W-1:0] out_shadow [NUM_PINS];
    logic [OSEL_W-1:0] out_active [NUM_PINS];
    logic [ISEL_W-1:0] in_shadow  [N_IN];
    logic [ISEL_W-1:0] in_active  [N_IN];

    logic [CFG_AW-2:0]   cfg_idx;
    logic                cfg_is_in;
    logic                wr_acc;
    logic                addr_oor;
    logic                use_shadow;
    logic                oe_live;
    logic [NUM_PINS-1:0] pin_synced;
    logic [NUM_PINS-1:0] pin_o_next;
    logic [NUM_PINS-1:0] pin_oe_next;
    logic [N_IN-1:0]     periph_in_next;

    assign cfg_idx   = cfg_addr[CFG_AW-2:0];
    assign cfg_is_in = cfg_addr[CFG_AW-1];
    assign wr_acc    = cfg_valid & cfg_ready;
    assign addr_oor  = cfg_is_in ? (32'(cfg_idx) >= N_IN) : (32'(cfg_idx) >= NUM_PINS);

    // The APPLY-cycle mux reads the shadow so the first IDLE cycle already drives the new table.
    assign use_shadow = (state == APPLY);
    // Pins may drive only when the register being loaded belongs to an IDLE cycle.
    assign oe_live    = ((state == IDLE) && !cfg_commit) || (state == APPLY);

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_sync
        pin_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk(clk),
            .rst(rst),
            .d  (pin_i[p]),
            .q  (pin_synced[p])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            hiz_cnt     <= '0;
            cfg_ready   <= 1'b1;
            commit_done <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            if (wr_acc && addr_oor) begin
                cfg_err <= 1'b1;
            end else if (cfg_err_clr) begin
                cfg_err <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (cfg_commit) begin
                        state     <= DRAIN;
                        hiz_cnt   <= CNT_W'(HIZ_CYCLES - 1);
                        cfg_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (hiz_cnt == '0) begin
                        state <= APPLY;
                    end else begin
                        hiz_cnt <= hiz_cnt - 1'b1;
                    end
                end
                APPLY: begin
                    state       <= IDLE;
                    cfg_ready   <= 1'b1;
                    commit_done <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                out_shadow[p] <= '1;
                out_active[p] <= '1;
            end
            for (int k = 0; k < N_IN; k++) begin
                in_shadow[k] <= '1;
                in_active[k] <= '1;
            end
        end else begin
            if (wr_acc && !addr_oor) begin
                if (cfg_is_in) begin
                    for (int k = 0; k < N_IN; k++) begin
                        if (32'(cfg_idx) == k) in_shadow[k] <= cfg_data[ISEL_W-1:0];
                    end
                end else begin
                    for (int p = 0; p < NUM_PINS; p++) begin
                        if (32'(cfg_idx) == p) out_shadow[p] <= cfg_data[OSEL_W-1:0];
                    end
                end
            end
            if (state == APPLY) begin
                out_active <= out_shadow;
                in_active  <= in_shadow;
            end
        end
    end

    always_comb begin
        logic [OSEL_W-1:0] osel;
        osel        = '0;
        pin_o_next  = '0;
        pin_oe_next = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            osel = use_shadow ? out_shadow[p] : out_active[p];
            for (int j = 0; j < N_OUT; j++) begin
                if (osel == OSEL_W'(j)) begin
                    pin_o_next[p]  = periph_out[j];
                    pin_oe_next[p] = periph_oe[j];
                end
            end
        end
    end

    always_comb begin
        logic [ISEL_W-1:0] isel;
        isel           = '0;
        periph_in_next = '0;
        for (int k = 0; k < N_IN; k++) begin
            isel = use_shadow ? in_shadow[k] : in_active[k];
            for (int p = 0; p < NUM_PINS; p++) begin
                if (isel == ISEL_W'(p)) periph_in_next[k] = pin_synced[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pin_o     <= '0;
            pin_oe    <= '0;
            periph_in <= '0;
        end else begin
            pin_o     <= pin_o_next;
            pin_oe    <= oe_live ? pin_oe_next : '0;
            periph_in <= periph_in_next;
        end
    end

`ifdef PIN_CROSSBAR_READBACK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_rdata <= '0;
        end else if (cfg_rd_en) begin
            cfg_rdata <= '1;
            if (!addr_oor) begin
                if (cfg_is_in) begin
                    for (int k = 0; k < N_IN; k++) begin
                        if (32'(cfg_idx) == k) cfg_rdata <= CFG_DW'(in_active[k]);
                    end
                end else begin
                    for (int p = 0; p < NUM_PINS; p++) begin
                        if (32'(cfg_idx) == p) cfg_rdata <= CFG_DW'(out_active[p]);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pin_crossbar.sv
// Directed self-checking bench for pin_crossbar at default parameters.
module tb_pin_crossbar;

    localparam int unsigned NUM_PINS = 16;
    localparam int unsigned N_OUT    = 32;
    localparam int unsigned N_IN     = 32;
    localparam int unsigned CFG_DW   = 6;
    localparam int unsigned CFG_AW   = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CFG_AW-1:0]   cfg_addr = '0;
    logic [CFG_DW-1:0]   cfg_data = '0;
    logic                cfg_commit = 1'b0;
    logic                commit_done;
    logic                cfg_err;
    logic                cfg_err_clr = 1'b0;
    logic [N_OUT-1:0]    periph_out = '0;
    logic [N_OUT-1:0]    periph_oe = '0;
    logic [N_IN-1:0]     periph_in;
    logic [NUM_PINS-1:0] pin_o;
    logic [NUM_PINS-1:0] pin_oe;
    logic [NUM_PINS-1:0] pin_i = '0;
`ifdef PIN_CROSSBAR_READBACK_EN
    logic                cfg_rd_en = 1'b0;
    logic [CFG_DW-1:0]   cfg_rdata;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    pin_crossbar #(
        .NUM_PINS          (16),
        .NUM_PERIPHERALS   (8),
        .OUTPUTS_PER_PERIPH(4),
        .INPUTS_PER_PERIPH (4),
        .SYNC_STAGES       (2),
        .HIZ_CYCLES        (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .commit_done(commit_done),
        .cfg_err    (cfg_err),
        .cfg_err_clr(cfg_err_clr),
        .periph_out (periph_out),
        .periph_oe  (periph_oe),
        .periph_in  (periph_in),
        .pin_o      (pin_o),
        .pin_oe     (pin_oe),
`ifdef PIN_CROSSBAR_READBACK_EN
        .cfg_rd_en  (cfg_rd_en),
        .cfg_rdata  (cfg_rdata),
`endif
        .pin_i      (pin_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [CFG_AW-1:0] addr, input logic [CFG_DW-1:0] data,
                      input logic commit);
        cfg_valid  = 1'b1;
        cfg_addr   = addr;
        cfg_data   = data;
        cfg_commit = commit;
        tick();
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // Leaves time just after the edge where commit_done is high.
    task automatic commit_wait();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        // Reset with every peripheral driving and every pin high.
        periph_out = '1;
        periph_oe  = '1;
        pin_i      = '1;
        repeat (3) tick();
        chk("rst pin_oe", 64'(pin_oe), 64'h0);
        chk("rst pin_o", 64'(pin_o), 64'h0);
        chk("rst periph_in", 64'(periph_in), 64'h0);
        chk("rst cfg_ready", 64'(cfg_ready), 64'h1);
        chk("rst commit_done", 64'(commit_done), 64'h0);
        chk("rst cfg_err", 64'(cfg_err), 64'h0);
        rst = 1'b1;
        repeat (4) tick();
        chk("unassigned pin_oe", 64'(pin_oe), 64'h0);
        chk("unassigned pin_o", 64'(pin_o), 64'h0);
        chk("unassigned periph_in", 64'(periph_in), 64'h0);

        // out[3] = 5, write and commit in the same cycle.
        periph_out = 32'h0000_0020;
        periph_oe  = 32'h0000_0020;
        pin_i      = '0;
        wr(6'd3, 6'd5, 1'b1);
        chk("drain1 cfg_ready", 64'(cfg_ready), 64'h0);
        chk("drain1 pin_oe", 64'(pin_oe), 64'h0);
        tick();
        chk("drain2 pin_oe", 64'(pin_oe), 64'h0);
        chk("drain2 commit_done", 64'(commit_done), 64'h0);
        tick();
        chk("apply pin_oe", 64'(pin_oe), 64'h0);
        chk("apply pin_o", 64'(pin_o), 64'h0);
        chk("apply cfg_ready", 64'(cfg_ready), 64'h0);
        tick();
        chk("new pin_oe", 64'(pin_oe), 64'h0008);
        chk("new pin_o", 64'(pin_o), 64'h0008);
        chk("commit_done pulse", 64'(commit_done), 64'h1);
        chk("idle cfg_ready", 64'(cfg_ready), 64'h1);
        tick();
        chk("commit_done low", 64'(commit_done), 64'h0);
        chk("steady pin_oe", 64'(pin_oe), 64'h0008);

        // in[7] = pin 2, then check SYNC_STAGES+1 latency.
        wr(6'h27, 6'd2, 1'b0);
        commit_wait();
        chk("in commit_done", 64'(commit_done), 64'h1);
        chk("in idle periph_in", 64'(periph_in), 64'h0);
        pin_i = 16'h0004;
        tick();
        chk("in lat1", 64'(periph_in), 64'h0);
        tick();
        chk("in lat2", 64'(periph_in), 64'h0);
        tick();
        chk("in lat3", 64'(periph_in), 64'h80);
        pin_i = 16'h0000;
        tick();
        tick();
        chk("in fall lat2", 64'(periph_in), 64'h80);
        tick();
        chk("in fall lat3", 64'(periph_in), 64'h0);

        // Out-of-range output index 20 must not alias pin 4.
        wr(6'd20, 6'd5, 1'b0);
        chk("oor err set", 64'(cfg_err), 64'h1);
        tick();
        chk("oor err sticky", 64'(cfg_err), 64'h1);
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        chk("oor err clr", 64'(cfg_err), 64'h0);
        cfg_err_clr = 1'b1;
        wr(6'd20, 6'd5, 1'b0);
        cfg_err_clr = 1'b0;
        chk("oor err wins", 64'(cfg_err), 64'h1);
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        chk("oor err clr2", 64'(cfg_err), 64'h0);
        commit_wait();
        chk("oor shadow pin_oe", 64'(pin_oe), 64'h0008);

        // Commit during DRAIN and a write during APPLY are both ignored; pin 0 fans out output 5.
        wr(6'd0, 6'd5, 1'b0);
        cfg_commit = 1'b1;
        tick();
        chk("busy ready drain1", 64'(cfg_ready), 64'h0);
        tick();
        chk("busy ready drain2", 64'(cfg_ready), 64'h0);
        cfg_commit = 1'b0;
        tick();
        cfg_valid = 1'b1;
        cfg_addr  = 6'd1;
        cfg_data  = 6'd5;
        chk("busy ready apply", 64'(cfg_ready), 64'h0);
        tick();
        cfg_valid = 1'b0;
        chk("busy commit_done", 64'(commit_done), 64'h1);
        chk("fanout pin_oe", 64'(pin_oe), 64'h0009);
        chk("fanout pin_o", 64'(pin_o), 64'h0009);
        pulses = 0;
        repeat (6) begin
            tick();
            if (commit_done) pulses++;
        end
        chk("extra commit_done", 64'(pulses), 64'h0);
        commit_wait();
        chk("apply write dropped", 64'(pin_oe), 64'h0009);

        // Reset in the middle of DRAIN discards staged writes.
        wr(6'd2, 6'd5, 1'b0);
        wr(6'd20, 6'd0, 1'b0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("mid drain pin_oe", 64'(pin_oe), 64'h0);
        chk("mid drain err", 64'(cfg_err), 64'h1);
        rst   = 1'b0;
        pin_i = 16'h0004;
        tick();
        chk("midrst pin_oe", 64'(pin_oe), 64'h0);
        chk("midrst pin_o", 64'(pin_o), 64'h0);
        chk("midrst cfg_ready", 64'(cfg_ready), 64'h1);
        chk("midrst cfg_err", 64'(cfg_err), 64'h0);
        chk("midrst commit_done", 64'(commit_done), 64'h0);
        rst = 1'b1;
        repeat (4) tick();
        chk("postrst periph_in", 64'(periph_in), 64'h0);
        chk("postrst pin_oe", 64'(pin_oe), 64'h0);
        commit_wait();
        chk("postrst commit_done", 64'(commit_done), 64'h1);
        chk("discarded pin_oe", 64'(pin_oe), 64'h0);
        chk("discarded periph_in", 64'(periph_in), 64'h0);
        wr(6'd6, 6'd5, 1'b1);
        repeat (3) tick();
        chk("fresh pin_oe", 64'(pin_oe), 64'h0040);
        chk("fresh pin_o", 64'(pin_o), 64'h0040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pin_crossbar.md
Name: pin_crossbar

Overview:
- Runtime-configurable routing fabric between peripheral I/O and the DUT pins.
- Generalises the fixed pin mux with:
  - shadow and active select tables, loaded over a config write port;
  - per-pin output-enable (tristate) control;
  - input synchronisers;
  - a break-before-make commit sequence.
- Instantiated once in top; config writes come from the USB command decoder.

Parameters:
- NUM_PINS, 16, number of DUT pins.
- NUM_PERIPHERALS, 8, number of peripheral slots.
- OUTPUTS_PER_PERIPH, 4, outputs per peripheral slot; N_OUT = NUM_PERIPHERALS*OUTPUTS_PER_PERIPH.
- INPUTS_PER_PERIPH, 4, inputs per peripheral slot; N_IN = NUM_PERIPHERALS*INPUTS_PER_PERIPH.
- SYNC_STAGES, 2, flops per pin input synchroniser (minimum 2).
- HIZ_CYCLES, 2, cycles all pins are held Hi-Z during a commit (minimum 1).

Ports:
- clk  in  1  system clock (FT601 clock domain)
- rst  in  1  synchronous, active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_addr  in  CFG_AW  bit MSB=0: output table, index = pin; MSB=1: input table, index = peripheral input
- cfg_data  in  CFG_DW  select code, zero-extended
- cfg_commit  in  1  request a copy of shadow tables into active tables
- commit_done  out  1  one-cycle pulse when the new tables take effect
- cfg_err  out  1  sticky; set when a write targets an out-of-range index
- cfg_err_clr  in  1  clears cfg_err
- periph_out  in  N_OUT  peripheral output values
- periph_oe  in  N_OUT  peripheral output enables
- periph_in  out  N_IN  routed, synchronised pin values to peripherals
- pin_o  out  NUM_PINS  pin drive value
- pin_oe  out  NUM_PINS  pin output enable; the top-level IOBUF uses it
- pin_i  in  NUM_PINS  raw pin input values

Behaviour:
- Widths:
  - OSEL_W = $clog2(N_OUT+1)
  - ISEL_W = $clog2(NUM_PINS+1)
  - CFG_DW = max(OSEL_W, ISEL_W)
  - CFG_AW = $clog2(max(NUM_PINS, N_IN)) + 1
- Select codes:
  - Output code >= N_OUT means the pin is unassigned: pin_oe=0, pin_o=0.
  - Input code >= NUM_PINS means the peripheral input is forced to 0.
  - Codes are truncated to OSEL_W/ISEL_W; no error is raised for either condition.
- Reset values:
  - All shadow and active entries are unassigned.
  - pin_o=0, pin_oe=0, periph_in=0, synchronisers=0.
  - cfg_ready=1, commit_done=0, cfg_err=0, FSM in IDLE.
- Config write:
  - A write is accepted on cfg_valid & cfg_ready and updates the shadow entry only.
  - Index >= NUM_PINS (output table) or >= N_IN (input table): write dropped, cfg_err set next cycle.
  - cfg_err_clr and a new error in the same cycle: error wins.
- Commit FSM states IDLE -> DRAIN -> APPLY -> IDLE:
  - IDLE: cfg_ready=1. On cfg_commit, go to DRAIN. A write accepted in the same cycle is included in the commit.
  - DRAIN: cfg_ready=0 and pin_oe forced 0 for HIZ_CYCLES cycles. pin_o continues from the old active table.
  - APPLY: one cycle; shadow copied to active, cfg_ready=0, pin_oe still 0. Next cycle: IDLE, commit_done=1.
  - cfg_commit outside IDLE is ignored.
  - Reset mid-commit: immediate return to reset values; the partially staged commit is discarded.
- Output path latency:
  - periph_out/periph_oe to pin_o/pin_oe is 1 cycle (registered mux).
  - The first cycle after APPLY drives from the new table.
  - Multiple pins may select the same output (fan-out is legal).
- Input path latency:
  - pin_i to periph_in is SYNC_STAGES+1 cycles (synchroniser, then registered mux).
  - The input path is unaffected by DRAIN; it switches tables at APPLY.

Optional Feature:
- PIN_CROSSBAR_READBACK_EN
- Defined:
  - adds ports cfg_rd_en (in, 1) and cfg_rdata (out, CFG_DW);
  - cfg_rdata returns the active-table entry at cfg_addr one cycle after cfg_rd_en;
  - out-of-range reads return all-ones and do not set cfg_err.
- Undefined: the ports are absent and there is no read logic.

Decomposition:
- Add to package lycan:
  - N_OUT, N_IN, OSEL_W, ISEL_W, CFG_DW, CFG_AW localparam functions;
  - typedef enum xbar_state_t {IDLE, DRAIN, APPLY}.
- One sub-module, pin_sync: per-bit SYNC_STAGES-flop synchroniser with reset to 0, instantiated across NUM_PINS.
- Mux trees stay inline.

Test Plan:
- Reset, then periph_oe/periph_out all 1 -> pin_oe=0 and pin_o=0 on every pin; periph_in=0.
- Write out[3]=5, commit, periph_out[5]=1, periph_oe[5]=1 -> pin_oe all 0 for 2 DRAIN cycles plus APPLY. Next cycle pin_oe[3]=1, pin_o[3]=1, commit_done pulses once.
- Write in[7]=2, commit, toggle pin_i[2] -> periph_in[7] follows 3 cycles later; all other periph_in bits stay 0.
- Write out-of-range index 20 (NUM_PINS=16) -> cfg_err=1 next cycle, shadow unchanged; cfg_err_clr -> 0.
- cfg_commit during DRAIN, and a write attempt during APPLY -> cfg_ready=0, commit ignored, exactly one commit_done pulse.
- Mid-DRAIN reset -> all outputs return to reset values; a later commit shows the pre-reset shadow writes were discarded.
